instruction_loader: RTL

- Writer side of the byte-addressed, big-endian instruction memory.
- Receives a program as a stream of bytes from the debug UART receiver and packs every 4 bytes into one 32-bit instruction, MSB first.
- Issues one write strobe per instruction at consecutive word addresses (0, 4, 8, ...).
- Stops on a halt instruction or when memory is full, then reports completion to the debug unit.

---
 rtl/instruction_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Packs a UART byte stream into big-endian instructions and writes them to
// consecutive word addresses until a halt word arrives or memory fills up.
module instruction_loader #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned INST_BITS = 32,
    parameter int unsigned CELLS = 256,
    parameter logic [INST_BITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NBITS-1:0]     i_rx_data,
    input  logic                 i_rx_valid,
    output logic [INST_BITS-1:0] o_addr,
    output logic [INST_BITS-1:0] o_data,
    output logic                 o_wr_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [INST_BITS-1:0] o_words
);

    localparam int unsigned BYTES = INST_BITS / NBITS;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned SHIFT_W = INST_BITS - NBITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - BYTES);
    localparam logic [INST_BITS-1:0] ADDR_STEP = INST_BITS'(BYTES);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e               state_q, state_d;
    logic [INST_BITS-1:0] addr_q, addr_d;
    logic [INST_BITS-1:0] data_q, data_d;
    logic [INST_BITS-1:0] words_q, words_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 accept;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        words_d    = words_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        accept     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    addr_d     = '0;
                    words_d    = '0;
                    cnt_d      = '0;
                    shift_d    = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = StRecv;
                end
            end
            StRecv: accept = i_rx_valid;
            StWrite: begin
                words_d = words_q + 1'b1;
                if (data_q == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (addr_q == LAST_ADDR) begin
                    done_d     = 1'b1;
                    overflow_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = StRecv;
                    // A byte arriving during the strobe starts the next word.
                    accept  = i_rx_valid;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            shift_d = {shift_q[SHIFT_W-NBITS-1:0], i_rx_data};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                data_d  = {shift_q, i_rx_data};
                state_d = StWrite;
            end
        end
    end

    // Strobe and busy are derived from the next state so they stay registered.
    assign wr_en_d = (state_d == StWrite);
    assign busy_d  = (state_d == StRecv) || (state_d == StWrite);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            words_q    <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            words_q    <= words_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_wr_en    = wr_en_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_words    = words_q;

endmodule
